// File: rtl/watch_pkg.sv
// watch_pkg: digit ranges and widths of the time-of-day digits. The stopwatch
// datapath and the display formatter use the same definitions, so all three
// blocks agree on digit widths.
//
// Contents:
//   *_MAX : largest legal value of each digit (the digit wraps to 0 after it)
//   *_W   : register width of each digit
package watch_pkg;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/time_digit_counter.sv
// time_digit_counter: one modulo-(MAX+1) time digit. It advances on a carry
// from the lower digit and on a user adjust pulse. If both arrive in the same
// cycle, the digit advances by two.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous, active-high reset (value <= RST_VAL)
//   carry_in  : tick-derived carry from the next lower digit
//   inc       : adjust pulse (+1); it never produces a carry_out
//   value     : registered digit value, 0..MAX
//   carry_out : carry_in & (value == MAX), driven from the pre-edge value
module time_digit_counter #(
    parameter int MAX     = 59,
    parameter int WIDTH   = 6,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carry_in,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] value_next;

    // Only the tick carry can ripple upward. An adjust pulse changes this
    // digit alone.
    assign carry_out = carry_in & (value == MAX_V);

    always_comb begin
        // NOTE: value_next gets a default before the case, so every path
        // assigns it and no latch is inferred.
        value_next = value;
        unique case ({carry_in, inc})
            2'b01, 2'b10: value_next = (value == MAX_V) ? '0 : value + WIDTH'(1);
            2'b11: begin
                // Two steps at once. Handle both wrap points explicitly.
                if (value == MAX_V)
                    value_next = WIDTH'(1);
                else if (value == MAX_M1)
                    value_next = '0;
                else
                    value_next = value + WIDTH'(2);
            end
            default: value_next = value;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values, and the carry chain stays consistent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= RST_V;
        else
            value <= value_next;
    end

endmodule

// File: rtl/watch_dp.sv
// watch_dp: time-keeping datapath for Watch mode. A divider turns clk into a
// TICK_HZ pulse. The pulse drives a centisecond/second/minute/hour carry chain,
// and the control unit's one-cycle adjust pulses bump individual digits
// without carrying.
//
// Ports:
//   clk        : system clock (CLK_FREQ Hz)
//   rst        : asynchronous, active-high reset
//   i_inc_sec  : adjust pulse, sec +1 mod 60 (no carry into min)
//   i_inc_min  : adjust pulse, min +1 mod 60 (no carry into hour)
//   i_inc_hour : adjust pulse, hour +1 mod 24
//   o_tick     : registered one-cycle pulse every CLK_FREQ/TICK_HZ cycles
//   o_msec     : centiseconds 0..99
//   o_sec      : seconds 0..59
//   o_min      : minutes 0..59
//   o_hour     : hours 0..23 (INIT_HOUR after reset)
module watch_dp
    import watch_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int INIT_HOUR = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc_sec,
    input  logic              i_inc_min,
    input  logic              i_inc_hour,
    output logic              o_tick,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             c_sec;
    logic             c_min;
    logic             c_hour;
    logic             unused_day_carry;

    // o_tick is high for the one cycle after the divider held DIV-1. The
    // divider wraps on the same edge, so the period is exactly DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            o_tick  <= 1'b0;
        end else if (div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
            o_tick  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            o_tick  <= 1'b0;
        end
    end

    // Centiseconds have no adjust input. Their carry_in is the registered tick.
    time_digit_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W), .RST_VAL(0)) u_msec (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (o_tick),
        .inc       (1'b0),
        .value     (o_msec),
        .carry_out (c_sec)
    );

    time_digit_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W), .RST_VAL(0)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (c_sec),
        .inc       (i_inc_sec),
        .value     (o_sec),
        .carry_out (c_min)
    );

    time_digit_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W), .RST_VAL(0)) u_min (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (c_min),
        .inc       (i_inc_min),
        .value     (o_min),
        .carry_out (c_hour)
    );

    // The day wrap has no consumer. Hours simply roll 23 -> 0.
    time_digit_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W), .RST_VAL(INIT_HOUR)) u_hour (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (c_hour),
        .inc       (i_inc_hour),
        .value     (o_hour),
        .carry_out (unused_day_carry)
    );

endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: directed bench for watch_dp with CLK_FREQ=1000 and TICK_HZ=100,
// so one tick arrives every 10 clocks. Inputs change on the falling edge, and
// outputs are sampled on the falling edge.
module tb_watch_dp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_inc_sec = 1'b0;
    logic       i_inc_min = 1'b0;
    logic       i_inc_hour = 1'b0;
    logic       o_tick;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] got_t;
    logic [23:0] exp_t;
    logic [16:0] got_hms;
    logic [16:0] exp_hms;
    bit          found;

    watch_dp #(.CLK_FREQ(1000), .TICK_HZ(100), .INIT_HOUR(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_inc_sec  (i_inc_sec),
        .i_inc_min  (i_inc_min),
        .i_inc_hour (i_inc_hour),
        .o_tick     (o_tick),
        .o_msec     (o_msec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pack_t(input int h, input int m, input int s, input int c);
        return {5'(h), 6'(m), 6'(s), 7'(c)};
    endfunction

    function automatic string tstr(input logic [23:0] t);
        return $sformatf("%0d:%0d:%0d.%0d", t[23:19], t[18:13], t[12:7], t[6:0]);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // which: 0 = sec, 1 = min, 2 = hour. Each pulse is one cycle high, then
    // one cycle low.
    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_inc_sec  = (which == 0);
            i_inc_min  = (which == 1);
            i_inc_hour = (which == 2);
            @(negedge clk);
            i_inc_sec  = 1'b0;
            i_inc_min  = 1'b0;
            i_inc_hour = 1'b0;
        end
    endtask

    // Stop on a falling edge where msec==99 and the tick is high, so the
    // next rising edge carries out of the centisecond digit.
    task automatic wait_wrap_tick(input string name);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (o_msec == 7'd99 && o_tick === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: msec=99 tick not seen within 2000 cycles (msec=%0d)", name, o_msec);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(12, 0, 0, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL reset_time: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
        n_checks++;
        if (o_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b expected 0", o_tick);
        end
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_tick !== ((k % 10) == 0)) begin
                n_fail++;
                $display("FAIL tick_cycle_%0d: got %b expected %b", k, o_tick, (k % 10) == 0);
            end
        end
        // Ticks seen at cycles 10 and 20 have been applied. The tick at
        // cycle 30 has not been applied yet.
        n_checks++;
        if (o_msec !== 7'd2) begin
            n_fail++;
            $display("FAIL msec_after_30: got %0d expected 2", o_msec);
        end
    endtask

    task automatic test_free_run();
        apply_reset();
        repeat (1001) @(negedge clk);
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(12, 0, 1, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL run_100_ticks: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
        repeat (59000) @(negedge clk);
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(12, 1, 0, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL run_6000_ticks: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
    endtask

    task automatic test_rollover();
        apply_reset();
        pulse(2, 11);
        pulse(1, 59);
        pulse(0, 59);
        got_hms = {o_hour, o_min, o_sec};
        exp_hms = {5'd23, 6'd59, 6'd59};
        n_checks++;
        if (got_hms !== exp_hms) begin
            n_fail++;
            $display("FAIL set_23_59_59: got %0d:%0d:%0d expected 23:59:59", o_hour, o_min, o_sec);
        end
        wait_wrap_tick("rollover_wait");
        @(negedge clk);
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(0, 0, 0, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL day_rollover: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
    endtask

    task automatic test_adjust_wrap();
        // Continues from 00:00:00.00. Msec stays well below 99 throughout.
        pulse(0, 59);
        pulse(0, 1);
        got_hms = {o_hour, o_min, o_sec};
        exp_hms = {5'd0, 6'd0, 6'd0};
        n_checks++;
        if (got_hms !== exp_hms) begin
            n_fail++;
            $display("FAIL sec_adjust_wrap: got %0d:%0d:%0d expected 0:0:0", o_hour, o_min, o_sec);
        end
        pulse(2, 23);
        n_checks++;
        if (o_hour !== 5'd23) begin
            n_fail++;
            $display("FAIL hour_to_23: got %0d expected 23", o_hour);
        end
        pulse(2, 1);
        got_hms = {o_hour, o_min, o_sec};
        n_checks++;
        if (got_hms !== exp_hms) begin
            n_fail++;
            $display("FAIL hour_adjust_wrap: got %0d:%0d:%0d expected 0:0:0", o_hour, o_min, o_sec);
        end
        pulse(1, 60);
        got_hms = {o_hour, o_min, o_sec};
        n_checks++;
        if (got_hms !== exp_hms) begin
            n_fail++;
            $display("FAIL min_adjust_wrap: got %0d:%0d:%0d expected 0:0:0", o_hour, o_min, o_sec);
        end
        @(negedge clk);
        i_inc_sec  = 1'b1;
        i_inc_min  = 1'b1;
        i_inc_hour = 1'b1;
        @(negedge clk);
        i_inc_sec  = 1'b0;
        i_inc_min  = 1'b0;
        i_inc_hour = 1'b0;
        got_hms = {o_hour, o_min, o_sec};
        exp_hms = {5'd1, 6'd1, 6'd1};
        n_checks++;
        if (got_hms !== exp_hms) begin
            n_fail++;
            $display("FAIL all_adjust_same_cycle: got %0d:%0d:%0d expected 1:1:1", o_hour, o_min, o_sec);
        end
    endtask

    task automatic test_carry_plus_adjust();
        apply_reset();
        pulse(1, 10);
        pulse(0, 59);
        wait_wrap_tick("coincide_wait_59");
        i_inc_sec = 1'b1;
        @(negedge clk);
        i_inc_sec = 1'b0;
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(12, 11, 1, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL carry_and_inc_at_59: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
        pulse(0, 57);
        wait_wrap_tick("coincide_wait_58");
        i_inc_sec = 1'b1;
        @(negedge clk);
        i_inc_sec = 1'b0;
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(12, 11, 0, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL carry_and_inc_at_58: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        pulse(2, 17);
        pulse(1, 33);
        pulse(0, 20);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (o_msec == 7'd47) found = 1'b1;
        end
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(5, 33, 20, 47);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL preset_05_33_20_47: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
        #2;
        rst = 1'b1;
        #1;
        got_t = {o_hour, o_min, o_sec, o_msec};
        exp_t = pack_t(12, 0, 0, 0);
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
        n_checks++;
        if (o_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_tick: got %b expected 0", o_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_tick !== (k == 10)) begin
                n_fail++;
                $display("FAIL post_reset_tick_cycle_%0d: got %b expected %b", k, o_tick, k == 10);
            end
        end
        got_t = {o_hour, o_min, o_sec, o_msec};
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL post_reset_time: got %s expected %s", tstr(got_t), tstr(exp_t));
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_rollover();
        test_adjust_wrap();
        test_carry_plus_adjust();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_dp.md
Name: watch_dp

Overview:
Time-keeping datapath for the Watch mode, directly downstream of the watch control unit. Holds hour/min/sec/centisecond counters, advances them from a divided clock tick, and applies the one-cycle adjust pulses (o_run_sec/o_run_min/o_run_hour) issued by the control unit. Outputs feed the FND/display formatter and the UART time reporter.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
TICK_HZ, 100, counter base rate in Hz (centisecond tick); CLK_FREQ/TICK_HZ must be an integer >= 2
INIT_HOUR, 12, hour value loaded on reset (0..23)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
i_inc_sec  input  1  one-cycle pulse: sec +1 mod 60, no carry into min
i_inc_min  input  1  one-cycle pulse: min +1 mod 60, no carry into hour
i_inc_hour  input  1  one-cycle pulse: hour +1 mod 24
o_tick  output  1  one-cycle pulse at TICK_HZ rate (debug / stopwatch sync)
o_msec  output  7  centiseconds 0..99
o_sec  output  6  seconds 0..59
o_min  output  6  minutes 0..59
o_hour  output  5  hours 0..23

Behaviour:
- Clock/reset: clk is the clock; rst is asynchronous, active-high.
- Reset (async, immediate): tick divider = 0, o_tick = 0, o_msec = 0, o_sec = 0, o_min = 0, o_hour = INIT_HOUR. Reset mid-count discards partial divider count; first tick after release is a full period later.
- Tick divider: counts 0..DIV-1, DIV = CLK_FREQ/TICK_HZ. o_tick is registered and high for exactly one cycle in the cycle after the divider holds DIV-1; the divider wraps to 0 on that edge. Period exactly DIV cycles.
- All outputs are registers; no combinational path from inputs to outputs.
- Carry chain, evaluated combinationally within one cycle, applied on one edge:
  - c_msec = o_tick; msec_next = (msec + c_msec) mod 100; c_sec = c_msec & (msec == 99).
  - sec_next = (sec + c_sec + i_inc_sec) mod 60; c_min = c_sec & (sec == 59).
  - min_next = (min + c_min + i_inc_min) mod 60; c_hour = c_min & (min == 59).
  - hour_next = (hour + c_hour + i_inc_hour) mod 24.
- Adjust pulses never generate carries; only tick-derived carries propagate.
- Simultaneous carry + adjust on the same digit: both add (digit advances by 2, mod range); carry-out is decided only by the carry-in and the pre-edge value (e.g. sec=59, carry and inc -> sec=1, min+1; sec=58, carry and inc -> sec=0, no carry).
- Latency: adjust pulse sampled at edge N -> new value visible after edge N. Tick-driven rollover from 23:59:59.99 -> 00:00:00.00 completes on a single edge.
- Adjust pulse held high for k cycles advances k times. The upstream control unit guarantees single-cycle pulses, so this is not an error case.
- Multiple adjust inputs high in the same cycle: each applied to its own digit independently.

Decomposition:
- Package watch_pkg: MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, width constants 7/6/6/5, shared with stopwatch datapath and display formatter.
- Sub-module time_digit_counter (params MAX, WIDTH, RST_VAL; inputs carry_in, inc; outputs value, carry_out), instantiated four times (msec with inc tied 0). Tick divider stays inline.

Test Plan:
(Bench parameters: CLK_FREQ=1000, TICK_HZ=100, so DIV=10.)
1. Reset then release -> outputs 12:00:00.00; o_tick first high 10 cycles after release, then every 10 cycles, width 1.
2. Free-run 100 ticks (1000 cycles) from reset -> 12:00:01.00; 6000 ticks -> 12:01:00.00.
3. Apply 11 i_inc_hour, 59 i_inc_min, 59 i_inc_sec pulses (1 cycle each, spaced) -> 23:59:59.xx. Run to msec=99 then one tick -> 00:00:00.00 on a single edge.
4. sec=59, i_inc_sec pulse with no tick -> sec=0, min unchanged. hour=23, i_inc_hour -> hour=0.
5. msec=99, sec=59, min=10; i_inc_sec coincident with o_tick -> msec=0, sec=1, min=11.
6. Assert rst asynchronously mid-divider (between edges) at 05:33:20.47 -> outputs 12:00:00.00 immediately, before the next edge; next o_tick exactly 10 cycles after release.
